// File: rtl/frigate_adc_sar_ctrl_if.sv
// rtl/frigate_adc_sar_ctrl_if.sv - SAR controller to 12-bit ADC macro connection.
// master = digital controller, slave = analog macro (or its model).
interface frigate_adc_sar_ctrl_if;
  logic        adc_en;
  logic        adc_rst;
  logic        adc_hold;
  logic [2:0]  adc_sel;
  logic [11:0] adc_data;
  logic        adc_cmp;

  modport master (
    output adc_en, adc_rst, adc_hold, adc_sel, adc_data,
    input  adc_cmp
  );

  modport slave (
    input  adc_en, adc_rst, adc_hold, adc_sel, adc_data,
    output adc_cmp
  );
endinterface

// File: rtl/frigate_adc_sar_ctrl.sv
// rtl/frigate_adc_sar_ctrl.sv - 12-bit successive-approximation ADC controller.
// Optional macro FRIGATE_ADC_SAR_CONT_EN adds continuous mode (cont) and ack/overrun tracking.
module frigate_adc_sar_ctrl #(
  parameter int SAMPLE_CYCLES = 4,
  parameter int SETTLE_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        start,
  input  logic [2:0]  chan,
`ifdef FRIGATE_ADC_SAR_CONT_EN
  input  logic        cont,
  input  logic        ack,
  output logic        overrun,
`endif
  output logic        busy,
  output logic        done,
  output logic [11:0] data_out,
  output logic [2:0]  data_chan,
  frigate_adc_sar_ctrl_if.master adc
);

  typedef enum logic [1:0] {IDLE, SAMPLE, CONV, DONE} state_t;

  localparam logic [7:0] SAMPLE_LAST = 8'(SAMPLE_CYCLES - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES);

  state_t      state, state_n;
  logic [7:0]  cnt, cnt_n;
  logic [3:0]  bitk, bitk_n;
  logic [11:0] code, code_n;
  logic        busy_n, done_n;
  logic [11:0] data_out_n;
  logic [2:0]  data_chan_n;
  logic        en_q, en_d, rst_q, rst_d, hold_q, hold_d;
  logic [2:0]  sel_q, sel_d;
  logic [11:0] data_q, data_d;
  logic [11:0] onehot, kept;
`ifdef FRIGATE_ADC_SAR_CONT_EN
  logic        pend, pend_n, overrun_n;
`endif

  assign adc.adc_en   = en_q;
  assign adc.adc_rst  = rst_q;
  assign adc.adc_hold = hold_q;
  assign adc.adc_sel  = sel_q;
  assign adc.adc_data = data_q;

  // The trial code in data_q already carries the decided upper bits plus a 1 at bitk.
  assign onehot = 12'd1 << bitk;
  assign kept   = adc.adc_cmp ? data_q : (data_q & ~onehot);

  always_comb begin
    state_n     = state;
    cnt_n       = cnt;
    bitk_n      = bitk;
    code_n      = code;
    busy_n      = busy;
    done_n      = 1'b0;
    data_out_n  = data_out;
    data_chan_n = data_chan;
    en_d        = en_q;
    rst_d       = rst_q;
    hold_d      = hold_q;
    sel_d       = sel_q;
    data_d      = data_q;
    case (state)
      IDLE: begin
        if (en && start) begin
          state_n = SAMPLE;
          cnt_n   = 8'd0;
          busy_n  = 1'b1;
          en_d    = 1'b1;
          sel_d   = chan;
        end
      end
      SAMPLE: begin
        if (cnt == SAMPLE_LAST) begin
          state_n = CONV;
          cnt_n   = 8'd0;
          bitk_n  = 4'd11;
          hold_d  = 1'b1;
          rst_d   = 1'b0;
          data_d  = 12'h800;
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      CONV: begin
        if (cnt == SETTLE_LAST) begin
          cnt_n = 8'd0;
          if (bitk == 4'd0) begin
            state_n = DONE;
            code_n  = kept;
            hold_d  = 1'b0;
            rst_d   = 1'b1;
            data_d  = 12'h000;
          end else begin
            bitk_n = bitk - 4'd1;
            data_d = kept | (onehot >> 1);
          end
        end else begin
          cnt_n = cnt + 8'd1;
        end
      end
      DONE: begin
        done_n      = 1'b1;
        data_out_n  = code;
        data_chan_n = sel_q;
        state_n     = IDLE;
        busy_n      = 1'b0;
        en_d        = 1'b0;
`ifdef FRIGATE_ADC_SAR_CONT_EN
        if (cont) begin
          state_n = SAMPLE;
          cnt_n   = 8'd0;
          busy_n  = 1'b1;
          en_d    = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
    // Disable aborts any conversion without publishing a result.
    if (state != IDLE && !en) begin
      state_n     = IDLE;
      busy_n      = 1'b0;
      done_n      = 1'b0;
      data_out_n  = data_out;
      data_chan_n = data_chan;
      en_d        = 1'b0;
      rst_d       = 1'b1;
      hold_d      = 1'b0;
      data_d      = 12'h000;
    end
`ifdef FRIGATE_ADC_SAR_CONT_EN
    pend_n    = done_n ? 1'b1 : (ack ? 1'b0 : pend);
    overrun_n = (done_n && pend && !ack) ? 1'b1 : (ack ? 1'b0 : overrun);
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= 8'd0;
      bitk      <= 4'd0;
      code      <= 12'h000;
      busy      <= 1'b0;
      done      <= 1'b0;
      data_out  <= 12'h000;
      data_chan <= 3'd0;
      en_q      <= 1'b0;
      rst_q     <= 1'b1;
      hold_q    <= 1'b0;
      sel_q     <= 3'd0;
      data_q    <= 12'h000;
`ifdef FRIGATE_ADC_SAR_CONT_EN
      pend      <= 1'b0;
      overrun   <= 1'b0;
`endif
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      bitk      <= bitk_n;
      code      <= code_n;
      busy      <= busy_n;
      done      <= done_n;
      data_out  <= data_out_n;
      data_chan <= data_chan_n;
      en_q      <= en_d;
      rst_q     <= rst_d;
      hold_q    <= hold_d;
      sel_q     <= sel_d;
      data_q    <= data_d;
`ifdef FRIGATE_ADC_SAR_CONT_EN
      pend      <= pend_n;
      overrun   <= overrun_n;
`endif
    end
  end

endmodule

// File: tb/tb_frigate_adc_sar_ctrl.sv
// tb/tb_frigate_adc_sar_ctrl.sv - Self-checking bench for frigate_adc_sar_ctrl.
// Define FRIGATE_ADC_SAR_CONT_EN to also exercise continuous mode and overrun.
module tb_frigate_adc_sar_ctrl;
  localparam int SAMP = 4;
  localparam int SETL = 1;
  localparam int BITC = SETL + 1;
  localparam int LAT  = SAMP + 12 * BITC + 1;

  logic        clk = 1'b0;
  logic        rst_n, en, start;
  logic [2:0]  chan;
  logic        busy, done;
  logic [11:0] data_out;
  logic [2:0]  data_chan;
  int          vin2;
  int          checks = 0;
  int          failures = 0;
`ifdef FRIGATE_ADC_SAR_CONT_EN
  logic        cont, ack, overrun;
`endif

  frigate_adc_sar_ctrl_if bus();

  // Comparator model with the input expressed in half-LSB units.
  assign bus.adc_cmp = (vin2 > 2 * int'(bus.adc_data));

  frigate_adc_sar_ctrl #(.SAMPLE_CYCLES(SAMP), .SETTLE_CYCLES(SETL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .start(start), .chan(chan),
`ifdef FRIGATE_ADC_SAR_CONT_EN
    .cont(cont), .ack(ack), .overrun(overrun),
`endif
    .busy(busy), .done(done), .data_out(data_out), .data_chan(data_chan),
    .adc(bus)
  );

  always #5 clk = ~clk;

  function automatic int ref_code(int v2);
    if (v2 <= 0) return 0;
    if ((v2 - 1) / 2 > 4095) return 4095;
    return (v2 - 1) / 2;
  endfunction

  function automatic logic [11:0] trial_code(int c, int k);
    return 12'(((c >> (k + 1)) << (k + 1)) | (1 << k));
  endfunction

  function automatic logic [24:0] out_vec();
    return {busy, done, data_out, data_chan, bus.adc_en, bus.adc_rst,
            bus.adc_hold, bus.adc_sel, bus.adc_data};
  endfunction

  localparam logic [24:0] RESET_VEC = {1'b0, 1'b0, 12'h000, 3'd0, 1'b0, 1'b1, 1'b0, 3'd0, 12'h000};

  // Caller is at a negedge; returns at the negedge where done is seen (lat=-1 if never).
  task automatic run_conv(input int v2, input logic [2:0] ch, output int lat,
                          output int terr, output int herr, output int serr);
    int exp_c;
    int k;
    exp_c = ref_code(v2);
    terr = 0; herr = 0; serr = 0; lat = -1;
    vin2 = v2; chan = ch; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chan = 3'($urandom);
    for (int n = 0; n <= 100; n++) begin
      if (n > 0) @(negedge clk);
      if (bus.adc_sel !== ch) serr++;
      if (n < SAMP) begin
        if (bus.adc_hold !== 1'b0 || bus.adc_en !== 1'b1 || bus.adc_rst !== 1'b1 || busy !== 1'b1) herr++;
      end else if (n < SAMP + 12 * BITC) begin
        k = 11 - (n - SAMP) / BITC;
        if (bus.adc_data !== trial_code(exp_c, k)) terr++;
        if (bus.adc_hold !== 1'b1 || bus.adc_rst !== 1'b0 || busy !== 1'b1) herr++;
      end else if (n == SAMP + 12 * BITC) begin
        if (bus.adc_hold !== 1'b0 || bus.adc_rst !== 1'b1 || bus.adc_data !== 12'h000 || busy !== 1'b1) herr++;
      end
      if (done === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; en = 1'b0; start = 1'b0; chan = 3'd0; vin2 = 0;
`ifdef FRIGATE_ADC_SAR_CONT_EN
    cont = 1'b0; ack = 1'b0;
`endif
    repeat (3) @(negedge clk);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL reset_values got=%h want=%h", out_vec(), RESET_VEC);
    end
    rst_n = 1'b1; en = 1'b1;
    @(negedge clk);
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL idle_after_reset got=%h want=%h", out_vec(), RESET_VEC);
    end
  endtask

  task automatic test_conversion;
    int lat, terr, herr, serr;
    run_conv(2001, 3'd3, lat, terr, herr, serr);
    checks++;
    if (lat !== LAT) begin failures++; $display("FAIL latency got=%0d want=%0d", lat, LAT); end
    checks++;
    if (data_out !== 12'h3E8 || data_chan !== 3'd3) begin
      failures++; $display("FAIL conv_1000 got=%h/%0d want=3e8/3", data_out, data_chan);
    end
    checks++;
    if (terr != 0 || herr != 0 || serr != 0) begin
      failures++; $display("FAIL conv_sequence trial_errs=%0d hold_errs=%0d sel_errs=%0d want=0", terr, herr, serr);
    end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL busy_at_done got=%b want=0", busy); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0) begin failures++; $display("FAIL done_single_cycle got=%b want=0", done); end
  endtask

  task automatic test_extremes;
    int lat, terr, herr, serr;
    int vals[2];
    vals[0] = 0; vals[1] = 8191;
    foreach (vals[i]) begin
      run_conv(vals[i], 3'(i + 1), lat, terr, herr, serr);
      checks++;
      if (data_out !== 12'(ref_code(vals[i])) || lat !== LAT || terr != 0) begin
        failures++;
        $display("FAIL extreme_%0d got=%h lat=%0d terr=%0d want=%h lat=%0d", vals[i], data_out, lat, terr, 12'(ref_code(vals[i])), LAT);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_random;
    int lat, terr, herr, serr, v2;
    logic [2:0] ch;
    for (int i = 0; i < 8; i++) begin
      v2 = int'($urandom_range(0, 8300));
      ch = 3'($urandom);
      run_conv(v2, ch, lat, terr, herr, serr);
      checks++;
      if (data_out !== 12'(ref_code(v2)) || data_chan !== ch || terr != 0 || herr != 0 || serr != 0) begin
        failures++;
        $display("FAIL random_%0d vin2=%0d got=%h/%0d want=%h/%0d terr=%0d herr=%0d serr=%0d",
                 i, v2, data_out, data_chan, 12'(ref_code(v2)), ch, terr, herr, serr);
      end
      repeat (1 + $urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  task automatic test_en_drop;
    int lat, terr, herr, serr, ndone;
    run_conv(2001, 3'd5, lat, terr, herr, serr);
    @(negedge clk);
    vin2 = 6000; chan = 3'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    en = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.adc_hold !== 1'b0 || bus.adc_rst !== 1'b1 || bus.adc_en !== 1'b0) begin
      failures++;
      $display("FAIL en_drop_idle busy=%b hold=%b rst=%b aen=%b want=0/0/1/0", busy, bus.adc_hold, bus.adc_rst, bus.adc_en);
    end
    en = 1'b1;
    ndone = 0;
    repeat (40) begin
      if (done === 1'b1) ndone++;
      @(negedge clk);
    end
    checks++;
    if (ndone != 0 || data_out !== 12'h3E8 || data_chan !== 3'd5) begin
      failures++;
      $display("FAIL en_drop_keep dones=%0d data=%h chan=%0d want=0/3e8/5", ndone, data_out, data_chan);
    end
  endtask

  task automatic test_back_to_back;
    int ndone, lat, terr, herr, serr;
    logic busy_at_done;
    vin2 = 3333; chan = 3'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    ndone = 0; busy_at_done = 1'b1;
    for (int n = 1; n <= 45; n++) begin
      @(negedge clk);
      if (n == 5) begin start = 1'b1; chan = 3'd6; end
      if (n == 6) start = 1'b0;
      if (done === 1'b1) begin ndone++; busy_at_done = busy; end
    end
    checks++;
    if (ndone != 1 || busy_at_done !== 1'b0 || data_chan !== 3'd2 || data_out !== 12'(ref_code(3333))) begin
      failures++;
      $display("FAIL start_ignored dones=%0d busy=%b chan=%0d data=%h want=1/0/2/%h",
               ndone, busy_at_done, data_chan, data_out, 12'(ref_code(3333)));
    end
    run_conv(1500, 3'd4, lat, terr, herr, serr);
    run_conv(77, 3'd7, lat, terr, herr, serr);
    checks++;
    if (lat !== LAT || data_out !== 12'(ref_code(77)) || data_chan !== 3'd7) begin
      failures++;
      $display("FAIL back_to_back lat=%0d data=%h chan=%0d want=%0d/%h/7", lat, data_out, data_chan, LAT, 12'(ref_code(77)));
    end
  endtask

  task automatic test_async_reset;
    int lat, terr, herr, serr;
    @(negedge clk);
    vin2 = 4000; chan = 3'd6; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (out_vec() !== RESET_VEC) begin
      failures++;
      $display("FAIL async_reset got=%h want=%h", out_vec(), RESET_VEC);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_conv(1234, 3'd1, lat, terr, herr, serr);
    checks++;
    if (lat !== LAT || data_out !== 12'(ref_code(1234))) begin
      failures++;
      $display("FAIL after_reset lat=%0d data=%h want=%0d/%h", lat, data_out, LAT, 12'(ref_code(1234)));
    end
  endtask

`ifdef FRIGATE_ADC_SAR_CONT_EN
  task automatic test_cont;
    int nd;
    int at[4];
    logic ov[4];
    logic bz[4];
    logic [11:0] dv[4];
    @(negedge clk);
    cont = 1'b1; vin2 = 401; chan = 3'd3; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    nd = 0;
    for (int n = 1; n <= 150 && nd < 4; n++) begin
      @(negedge clk);
      if (n == 88) ack = 1'b1;
      if (n == 89) begin
        ack = 1'b0;
        checks++;
        if (overrun !== 1'b0) begin failures++; $display("FAIL ack_clears got=%b want=0", overrun); end
        cont = 1'b0;
      end
      if (done === 1'b1) begin
        at[nd] = n; ov[nd] = overrun; bz[nd] = busy; dv[nd] = data_out; nd++;
      end
    end
    checks++;
    if (nd != 4 || at[0] != LAT || at[1] != 2 * LAT || at[2] != 3 * LAT || at[3] != 4 * LAT) begin
      failures++; $display("FAIL cont_period dones=%0d first=%0d second=%0d want=4/%0d/%0d", nd, at[0], at[1], LAT, 2 * LAT);
    end
    checks++;
    if (dv[0] !== 12'h0C8 || dv[1] !== 12'h0C8 || dv[3] !== 12'h0C8) begin
      failures++; $display("FAIL cont_data got=%h/%h/%h want=0c8", dv[0], dv[1], dv[3]);
    end
    checks++;
    if (ov[0] !== 1'b0 || ov[1] !== 1'b1 || ov[3] !== 1'b0) begin
      failures++; $display("FAIL overrun got=%b%b%b want=010", ov[0], ov[1], ov[3]);
    end
    checks++;
    if (bz[0] !== 1'b1 || bz[3] !== 1'b0) begin
      failures++; $display("FAIL cont_busy got=%b%b want=10", bz[0], bz[3]);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_conversion();
    test_extremes();
    test_random();
    test_en_drop();
    test_back_to_back();
    test_async_reset();
`ifdef FRIGATE_ADC_SAR_CONT_EN
    test_cont();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout simulation exceeded bound");
    $fatal(1, "timeout");
  end

endmodule
